// File: rtl/sspis_wbm.sv
// Bridges level-held register requests from the SPI slave front end onto single-beat
// Wishbone classic cycles, with a bus timeout and a sticky error flag.
module sspis_wbm #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [31:0] reg_addr,
    input  logic [3:0]  reg_be,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        bus_err,
    input  logic        bus_err_clr
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             timeout;
    logic             fail;
    logic             finish;

    assign req     = reg_wr | reg_rd;
    // A timeout only fires when the slave is silent in that same cycle.
    assign timeout = (TIMEOUT != 0) && (cnt == CNT_LAST) && !wbm_ack_i && !wbm_err_i;
    assign fail    = wbm_err_i | timeout;
    assign finish  = wbm_ack_i | fail;

    assign wbm_stb_o = wbm_cyc_o;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUS;
            BUS:     if (finish) state_nxt = DONE;
            DONE:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_sel_o <= '0;
            wbm_dat_o <= '0;
            reg_rdata <= '0;
            reg_ack   <= 1'b0;
            cnt       <= '0;
        end else begin
            reg_ack <= 1'b0;
            if (state == IDLE && req) begin
                // Write wins when both requests are raised together.
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= reg_wr;
                wbm_adr_o <= reg_addr;
                wbm_dat_o <= reg_wdata;
                wbm_sel_o <= reg_wr ? reg_be : 4'hF;
                cnt       <= '0;
            end else if (state == BUS) begin
                cnt <= cnt + 1'b1;
                if (finish) begin
                    wbm_cyc_o <= 1'b0;
                    reg_ack   <= 1'b1;
                    if (!wbm_we_o) begin
                        reg_rdata <= fail ? ERR_RDATA : wbm_dat_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (state == BUS && fail) begin
            bus_err <= 1'b1;
        end else if (bus_err_clr) begin
            bus_err <= 1'b0;
        end
    end

endmodule
